// File: rtl/pc_gen.sv
// pc_gen: fetch-head program counter with valid/ready issue, redirect/stall handling and epoch tagging.
// Optional build macro PC_GEN_MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VEC.
module pc_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_next_seq_o,
  output logic            epoch_o,
  output logic            misalign_o
);

  localparam int unsigned AlignW = 2;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            misalign_q, misalign_d;
  logic            fire_c;
  logic            misaligned_c;
  logic [XLEN-1:0] aligned_target_c;

  assign pc_next_seq_o    = pc_q + XLEN'(INSTR_BYTES);
  assign pc_valid_o       = (state_q == RUN) && !stall_i;
  assign fire_c           = pc_valid_o && fetch_ready_i && !stall_i;
  assign misaligned_c     = |redirect_target_i[AlignW-1:0];
  assign aligned_target_c = {redirect_target_i[XLEN-1:AlignW], {AlignW{1'b0}}};

  assign pc_o       = pc_q;
  assign epoch_o    = epoch_q;
  assign misalign_o = misalign_q;

  // State, PC, epoch and trap-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      epoch_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      misalign_q <= misalign_d;
    end
  end

  // Redirect outranks stall and the fetch handshake; a same-cycle fire keeps the old epoch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    misalign_d = 1'b0;
    if (redirect_valid_i) begin
      state_d = BUBBLE;
      epoch_d = ~epoch_q;
      if (TrapEn && misaligned_c) begin
        pc_d       = TRAP_VEC;
        misalign_d = 1'b1;
      end else begin
        pc_d = aligned_target_c;
      end
    end else begin
      unique case (state_q)
        BOOT, BUBBLE: state_d = RUN;
        RUN:          state_d = RUN;
        default:      state_d = BOOT;
      endcase
      if (fire_c) begin
        pc_d = pc_next_seq_o;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus random bench for pc_gen against a cycle-level behavioural model.
module tb_pc_gen;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        fetch_ready_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic [31:0] pc_next_seq_o;
  logic        epoch_o;
  logic        misalign_o;

  pc_gen dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .fetch_ready_i     (fetch_ready_i),
    .pc_o              (pc_o),
    .pc_valid_o        (pc_valid_o),
    .pc_next_seq_o     (pc_next_seq_o),
    .epoch_o           (epoch_o),
    .misalign_o        (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: PC, epoch, and a count of cycles during which nothing may be offered.
  logic [31:0] m_pc;
  logic        m_epoch;
  int          m_bub;
  logic        m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_epoch = 1'b0;
    m_bub   = 1;
    m_mis   = 1'b0;
  endtask

  // Apply inputs, check every output against the model, then advance one clock.
  task automatic step(input logic st, input logic rv, input logic [31:0] tg, input logic rd);
    logic exp_v;
    stall_i           = st;
    redirect_valid_i  = rv;
    redirect_target_i = tg;
    fetch_ready_i     = rd;
    #1;
    exp_v = (m_bub == 0) && !st;
    chk("pc_o",          pc_o,                  m_pc);
    chk("pc_valid_o",    {31'b0, pc_valid_o},   {31'b0, exp_v});
    chk("pc_next_seq_o", pc_next_seq_o,         m_pc + 32'd4);
    chk("epoch_o",       {31'b0, epoch_o},      {31'b0, m_epoch});
    chk("misalign_o",    {31'b0, misalign_o},   {31'b0, m_mis});
    @(posedge clk);
    if (rv) begin
      m_epoch = ~m_epoch;
      m_bub   = 1;
      if (TRAP_EN && (tg[1:0] != 2'b00)) begin
        m_pc  = TRAP;
        m_mis = 1'b1;
      end else begin
        m_pc  = tg & 32'hFFFF_FFFC;
        m_mis = 1'b0;
      end
    end else begin
      if (exp_v && rd) m_pc = m_pc + 32'd4;
      if (m_bub > 0) m_bub--;
      m_mis = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [31:0] tg;
    rst_n             = 1'b0;
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = 32'h0;
    fetch_ready_i     = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc",    pc_o,                32'h0);
    chk("reset_valid", {31'b0, pc_valid_o}, 32'h0);
    chk("reset_epoch", {31'b0, epoch_o},    32'h0);
    chk("reset_mis",   {31'b0, misalign_o}, 32'h0);
    rst_n = 1'b1;

    // Boot bubble, then 0x0, 0x4, 0x8, 0xC
    step(0, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1);
    chk("seq_pc_10", pc_o, 32'h10);

    // Stall 3 cycles, fetch not ready 2 cycles, then 0x10 issues once
    repeat (3) step(1, 0, 32'h0, 1);
    repeat (2) step(0, 0, 32'h0, 0);
    chk("hold_pc_10", pc_o, 32'h10);
    step(0, 0, 32'h0, 1);
    chk("after_hold_pc_14", pc_o, 32'h14);

    // Redirect coinciding with a fire at 0x20
    repeat (3) step(0, 0, 32'h0, 1);
    chk("pre_redir_pc_20", pc_o, 32'h20);
    step(0, 1, 32'h200, 1);
    chk("redir_pc_200",   pc_o,             32'h200);
    chk("redir_epoch_1",  {31'b0, epoch_o}, 32'h1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    chk("redir_pc_204", pc_o, 32'h204);

    // Back-to-back redirects under stall: epoch returns to original
    step(1, 1, 32'h3000, 1);
    step(1, 1, 32'h3000, 1);
    chk("b2b_epoch", {31'b0, epoch_o}, 32'h1);
    chk("b2b_pc",    pc_o,             32'h3000);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    chk("b2b_pc_3004", pc_o, 32'h3004);

    // Wrap-around at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 32'h0, 1);
    chk("wrap_next_seq", pc_next_seq_o, 32'h0);
    step(0, 0, 32'h0, 1);
    chk("wrap_pc_0", pc_o, 32'h0);

    // Misaligned target
    step(0, 1, 32'h402, 1);
    chk("mis_pc",  pc_o,                TRAP_EN ? 32'h100 : 32'h400);
    chk("mis_out", {31'b0, misalign_o}, {31'b0, TRAP_EN});
    step(0, 0, 32'h0, 1);
    chk("mis_pulse_end", {31'b0, misalign_o}, 32'h0);

    // Reset asserted in the middle of a bubble
    step(0, 1, 32'h402, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc",    pc_o,                32'h0);
    chk("midrst_valid", {31'b0, pc_valid_o}, 32'h0);
    chk("midrst_epoch", {31'b0, epoch_o},    32'h0);
    chk("midrst_mis",   {31'b0, misalign_o}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tg = $urandom();
      if ($urandom_range(7) == 0) tg = 32'hFFFF_FFF8;
      step(($urandom_range(3) == 0), ($urandom_range(9) == 0), tg, ($urandom_range(9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
